mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_pkg.sv | 5 +
 rtl/mul_seq_pp.sv | 10 +
 rtl/mul_seq_ctrl.sv | 82 ++++++++
 tb/tb_mul_seq_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: state encoding and step count shared by the sequential multiplier.
package mul_seq_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int NUM_STEPS = 4;
endpackage

// File: rtl/mul_seq_pp.sv
// mul_seq_pp: combinational unsigned HxH->2H multiplier, kept standalone to map onto one DSP slice.
module mul_seq_pp #(
  parameter int H = 16
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-1:0] p
);
  assign p = {{H{1'b0}}, x} * {{H{1'b0}}, y};
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential WIDTHxWIDTH multiplier, four half-width partial products through one shared multiplier.
// Define MUL_SEQ_ZERO_SKIP_EN to finish a zero-operand multiply one cycle after acceptance.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);
  localparam int H = WIDTH / 2;
  localparam logic [1:0] LAST = 2'(NUM_STEPS - 1);
  state_t             state;
  logic [1:0]         step;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc, pp_sh;
  logic [H-1:0]       x, y;
  logic [WIDTH-1:0]   p;
  // step[0] picks the a half, step[1] the b half: lo*lo, hi*lo, lo*hi, hi*hi
  always_comb begin
    x = step[0] ? a_r[WIDTH-1:H] : a_r[H-1:0];
    y = step[1] ? b_r[WIDTH-1:H] : b_r[H-1:0];
    pp_sh = (step == LAST) ? {p, {WIDTH{1'b0}}} :
            (step == 2'd0) ? {{WIDTH{1'b0}}, p} : {{H{1'b0}}, p, {H{1'b0}}};
  end
  mul_seq_pp #(.H(H)) u_pp (.x(x), .y(y), .p(p));
  assign out = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= 2'd0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_r      <= a;
          b_r      <= b;
          acc      <= '0;
          step     <= 2'd0;
          state    <= MUL;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        MUL:
`ifdef MUL_SEQ_ZERO_SKIP_EN
          if (a_r == '0 || b_r == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else
`endif
          begin
            acc  <= acc + pp_sh;
            step <= step + 2'd1;
            if (step == LAST) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and random checks of mul_seq_ctrl against hand-computed and reference products.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] out, held;
  int          vectors = 0;
  int          miscompares = 0;
  always #5 clk = ~clk;
  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int zlat(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_SEQ_ZERO_SKIP_EN
    return (x == 0 || y == 0) ? 1 : 4;
`else
    return 4;
`endif
  endfunction
  // accept at edge N, count edges until out_valid, check product, then hand it off
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int lat);
    int k;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_out"}, out, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {61'd0, in_ready, busy, out_valid}, 64'h4);
  endtask
  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_flags", {61'd0, in_ready, busy, out_valid}, 64'h4);
    check("rst_out", out, 64'd0);
    do_op("small", 32'h3, 32'h5, 64'd15, 4);
    do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4);
    do_op("mixed", 32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000, 4);
    // stall in DONE with in_valid pestering the controller
    in_valid = 1'b1;
    a = 32'h0000_1000;
    b = 32'h0000_0010;
    tick();
    a = 32'h5555_5555;
    b = 32'hAAAA_AAAA;
    repeat (4) tick();
    check("stall_done", 64'(out_valid), 64'd1);
    held = out;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_out", out, 64'h0000_0000_0001_0000);
      check("stall_flags", {61'd0, in_ready, busy, out_valid}, 64'h3);
    end
    check("stall_held", out, held);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("stall_release", {61'd0, in_ready, busy, out_valid}, 64'h4);
    tick();
    check("stall_noaccept", 64'(busy), 64'd0);
    // reset while step2 is pending
    in_valid = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", {61'd0, in_ready, busy, out_valid}, 64'h4);
    check("abort_out", out, 64'd0);
    do_op("after_abort", 32'h2, 32'h3, 64'd6, 4);
    do_op("zero_a", 32'h0, 32'hDEAD_BEEF, 64'd0, zlat(32'h0, 32'hDEAD_BEEF));
    do_op("zero_b", 32'h7, 32'h0, 64'd0, zlat(32'h7, 32'h0));
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op("rand", ra, rb, {32'd0, ra} * {32'd0, rb}, zlat(ra, rb));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
